a_bram_request_arbiter: RTL and testbench
=========================================

// Module: a_bram_request_arbiter
// PURPOSE
// - Shares Alice's single AXI-manager BRAM request channel among NUM_REQ post-processing requesters
//   (qubit, EV random bit, PA random bit, secret key 1, secret key 2).
// - Round-robin picks one pending requester and issues a one-hot request with a 1-cycle request_valid
//   to the Alice BRAM controller.
// - Waits for that controller's new_round, then returns a per-requester done pulse.
// - A watchdog flags a stalled PC handshake.
// PARAMETERS
// - NUM_REQ    5        number of requesters; bit map [4]=qubit [3]=EVrb [2]=PArb [1]=sk1 [0]=sk2
// - TIMEOUT_W  24       watchdog counter width
// - TIMEOUT    2**24-1  cycles allowed in WAIT_ROUND before error
// PORTS
// - clk            in   1        clock
// - rst_n          in   1        synchronous active-low reset
// - req            in   NUM_REQ  level request per requester; held high until its done pulse
// - req_mask       in   NUM_REQ  1 = requester disabled (ignored by the picker)
// - ctrl_ready     in   1        BRAM controller ready (high only while it can accept request_valid)
// - new_round      in   1        1-cycle pulse from the BRAM controller: PC round complete
// - clr_err        in   1        pulse; clears timeout_err and leaves ERROR
// - request_valid  out  1        1-cycle pulse to the BRAM controller
// - req_vec        out  NUM_REQ  one-hot request bits; stable from ISSUE until DONE
// - done           out  NUM_REQ  1-cycle pulse on the bit of the served requester
// - busy           out  1        high in every state except IDLE
// - timeout_err    out  1        sticky watchdog error
// - arb_state      out  3        current FSM state, for debug
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state=IDLE, rr_ptr=0, grant=0, timer=0.
//   - All outputs are 0.
//   - Asserting reset mid-operation aborts the round; no done pulse is produced.
// - eligible = req & ~req_mask.
// - Picker: search eligible from index rr_ptr upward, wrapping NUM_REQ-1 -> 0; the first set bit wins.
// - States, encoded 3'd0..3'd4:
//   - IDLE: if |eligible && ctrl_ready, register the one-hot grant and go to ISSUE; otherwise stay.
//   - ISSUE:
//     - If ctrl_ready, drive request_valid=1 and req_vec=grant for this cycle, clear timer, go to WAIT_ROUND.
//     - If ctrl_ready has dropped, go to IDLE with no pulse.
//   - WAIT_ROUND:
//     - req_vec is held; timer increments each cycle.
//     - new_round -> DONE.
//     - Else timer==TIMEOUT-1 -> ERROR.
//     - new_round has priority over timeout when both occur in the same cycle.
//   - DONE:
//     - done[grant]=1 for exactly 1 cycle.
//     - rr_ptr = (index(grant)+1) mod NUM_REQ.
//     - req_vec cleared; go to IDLE.
//   - ERROR:
//     - timeout_err=1, held sticky; req_vec cleared; no done pulse.
//     - clr_err -> IDLE with timeout_err=0; rr_ptr advances past the failed requester.
//     - clr_err in any other state is ignored.
// - Latency: IDLE with a request and ctrl_ready -> request_valid 2 cycles later.
//   DONE follows new_round by 1 cycle; done is registered.
// - A requester that drops req before its grant is not served and not latched.
//   req changes after the grant do not affect the current round.
// - Masking or unmasking mid-round affects only the next pick.
// - Fairness: a continuously requesting requester waits at most NUM_REQ-1 rounds.
// - request_valid is never asserted while ctrl_ready=0.
//   At most one request_valid per new_round.
// STRUCTURE
// - The shared QKD header holds:
//   - request-bit index defines (QUBIT/EVRB/PARB/SK1/SK2);
//   - arbiter state encodings;
//   - the default TIMEOUT.
// - Sub-module a_rr_picker: combinational. Inputs: eligible and rr_ptr. Outputs: one-hot grant and any_valid.
// - The top level holds the FSM, timer, rr_ptr and output registers.
// TESTING
// - Single requester: req=5'b10000, ctrl_ready=1 -> request_valid pulse with req_vec=10000 two cycles later;
//   new_round -> done=10000 one cycle later; busy falls.
// - Round-robin: req=5'b11111 held, rr_ptr=0; each round is answered by new_round ->
//   grants in order 00001,00010,00100,01000,10000,00001.
// - Mask and drop:
//   - req=5'b00011, req_mask=5'b00001 -> only 00010 is granted.
//   - req[1] dropped before ctrl_ready rises -> no request_valid is issued.
// - ctrl_ready falls in ISSUE -> no request_valid; FSM returns to IDLE and re-issues when ctrl_ready returns.
// - Timeout (TIMEOUT=16), no new_round:
//   - timeout_err=1 after 16 WAIT_ROUND cycles; no done pulse.
//   - clr_err -> IDLE; next grant is the following index.
//   - Same-cycle case: new_round arriving together with timeout -> done pulse and no error.
// - Reset asserted during WAIT_ROUND -> all outputs 0 the next cycle and rr_ptr=0;
//   a stale new_round after reset is ignored.

Source files
------------

// File: rtl/a_bram_request_arbiter_pkg.sv
// Shared QKD header for the BRAM request arbiter: request-bit map, FSM encodings
// and the default watchdog limit.
package a_bram_request_arbiter_pkg;

    localparam int REQ_QUBIT = 4;
    localparam int REQ_EVRB  = 3;
    localparam int REQ_PARB  = 2;
    localparam int REQ_SK1   = 1;
    localparam int REQ_SK2   = 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam int          ARB_TIMEOUT_W = 24;
    localparam int unsigned ARB_TIMEOUT   = 32'd16777215;

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic int onehot_to_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/a_rr_picker.sv
// Combinational round-robin picker: first eligible bit at or above i_rr_ptr, wrapping.
// Zero latency; no flow control of its own.
module a_rr_picker
#(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_any_valid
);

    always_comb begin
        int w_idx;
        w_idx       = 0;
        o_grant     = '0;
        o_any_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!o_any_valid && i_eligible[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_any_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/a_bram_request_arbiter.sv
// Round-robin share of Alice's BRAM request channel; request_valid 2 cycles after a pick,
// done 1 cycle after new_round. Picks only while ctrl_ready; withdraws to IDLE if it drops in ISSUE.
module a_bram_request_arbiter
    import a_bram_request_arbiter_pkg::*;
#(
    parameter int          NUM_REQ   = 5,
    parameter int          TIMEOUT_W = ARB_TIMEOUT_W,
    parameter int unsigned TIMEOUT   = ARB_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic               ctrl_ready,
    input  logic               new_round,
    input  logic               clr_err,
    output logic               request_valid,
    output logic [NUM_REQ-1:0] req_vec,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               timeout_err,
    output logic [2:0]         arb_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic [2:0]           r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [NUM_REQ-1:0]   r_grant;
    logic [TIMEOUT_W-1:0] r_timer;
    logic                 r_request_valid;
    logic [NUM_REQ-1:0]   r_req_vec;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_timeout_err;

    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_any_valid;
    int                   w_grant_idx;
    logic [PTR_W-1:0]     w_next_ptr;

    assign w_eligible = req & ~req_mask;

    a_rr_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_eligible  (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_pick),
        .o_any_valid (w_any_valid)
    );

    // Pointer moves one past the requester just served or just failed.
    always_comb begin
        w_grant_idx = onehot_to_idx(32'(r_grant));
        w_next_ptr  = '0;
        if (w_grant_idx < NUM_REQ - 1) w_next_ptr = PTR_W'(w_grant_idx + 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_grant         <= '0;
            r_timer         <= '0;
            r_request_valid <= 1'b0;
            r_req_vec       <= '0;
            r_done          <= '0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_request_valid <= 1'b0;
            r_done          <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid && ctrl_ready) begin
                        r_grant <= w_pick;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ctrl_ready) begin
                        r_request_valid <= 1'b1;
                        r_req_vec       <= r_grant;
                        r_timer         <= '0;
                        r_state         <= ST_WAIT;
                    end else begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // A round completing on the last allowed cycle still counts as served.
                    if (new_round) begin
                        r_done    <= r_grant;
                        r_req_vec <= '0;
                        r_state   <= ST_DONE;
                    end else if (r_timer == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_req_vec     <= '0;
                        r_state       <= ST_ERROR;
                    end
                end
                ST_DONE: begin
                    r_rr_ptr <= w_next_ptr;
                    r_grant  <= '0;
                    r_state  <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (clr_err) begin
                        r_timeout_err <= 1'b0;
                        r_rr_ptr      <= w_next_ptr;
                        r_grant       <= '0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign request_valid = r_request_valid;
    assign req_vec       = r_req_vec;
    assign done          = r_done;
    assign busy          = (r_state != ST_IDLE);
    assign timeout_err   = r_timeout_err;
    assign arb_state     = r_state;

endmodule

// File: tb/tb_a_bram_request_arbiter.sv
// Randomized round-level bench for a_bram_request_arbiter against a pointer-and-scan model.
module tb_a_bram_request_arbiter;

    localparam int N   = 5;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] req_mask;
    logic         ctrl_ready;
    logic         new_round;
    logic         clr_err;
    logic         request_valid;
    logic [N-1:0] req_vec;
    logic [N-1:0] done;
    logic         busy;
    logic         timeout_err;
    logic [2:0]   arb_state;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    a_bram_request_arbiter #(
        .NUM_REQ   (N),
        .TIMEOUT_W (8),
        .TIMEOUT   (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_mask      (req_mask),
        .ctrl_ready    (ctrl_ready),
        .new_round     (new_round),
        .clr_err       (clr_err),
        .request_valid (request_valid),
        .req_vec       (req_vec),
        .done          (done),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .arb_state     (arb_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // First eligible index scanning upward from ptr with wrap; -1 if none.
    function automatic int model_pick(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++) begin
            if (e[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // mode 0: new_round on WAIT cycle d; mode 1: let the watchdog fire then clear it.
    task automatic run_round(input logic [N-1:0] r, input logic [N-1:0] m, input int mode, input int d);
        logic [N-1:0] elig;
        logic [N-1:0] oh;
        int w;
        elig       = r & ~m;
        req        = r;
        req_mask   = m;
        ctrl_ready = 1'b1;
        new_round  = 1'b0;
        clr_err    = 1'b0;
        if (elig == '0) begin
            repeat (3) step();
            chk("empty_busy", 32'(busy), 32'd0);
            chk("empty_rv", 32'(request_valid), 32'd0);
            return;
        end
        w  = model_pick(elig, m_ptr);
        oh = N'(1) << w;
        step();
        chk("issue_rv", 32'(request_valid), 32'd0);
        chk("issue_busy", 32'(busy), 32'd1);
        step();
        chk("rv_pulse", 32'(request_valid), 32'd1);
        chk("req_vec", 32'(req_vec), 32'(oh));
        // Inputs wander after the grant; the round must not notice.
        req        = N'($urandom);
        req_mask   = N'($urandom);
        ctrl_ready = 1'($urandom);
        clr_err    = 1'($urandom);
        if (mode == 1) begin
            repeat (TMO - 1) step();
            chk("pre_tmo_err", 32'(timeout_err), 32'd0);
            chk("pre_tmo_vec", 32'(req_vec), 32'(oh));
            clr_err = 1'b0;
            step();
            chk("tmo_err", 32'(timeout_err), 32'd1);
            chk("tmo_state", 32'(arb_state), 32'd4);
            chk("tmo_done", 32'(done), 32'd0);
            chk("tmo_vec", 32'(req_vec), 32'd0);
            step();
            chk("tmo_sticky", 32'(timeout_err), 32'd1);
            chk("tmo_done2", 32'(done), 32'd0);
            clr_err = 1'b1;
            step();
            clr_err = 1'b0;
            chk("clr_err", 32'(timeout_err), 32'd0);
            chk("clr_busy", 32'(busy), 32'd0);
        end else begin
            repeat (d - 1) step();
            if (d > 1) chk("rv_single", 32'(request_valid), 32'd0);
            chk("wait_vec", 32'(req_vec), 32'(oh));
            chk("wait_state", 32'(arb_state), 32'd2);
            new_round = 1'b1;
            clr_err   = 1'b0;
            step();
            new_round = 1'b0;
            chk("done", 32'(done), 32'(oh));
            chk("done_err", 32'(timeout_err), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
            step();
            chk("done_pulse", 32'(done), 32'd0);
            chk("after_busy", 32'(busy), 32'd0);
        end
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_mask   = '0;
        ctrl_ready = 1'b0;
        new_round  = 1'b0;
        clr_err    = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_rv", 32'(request_valid), 32'd0);
        chk("rst_vec", 32'(req_vec), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_state", 32'(arb_state), 32'd0);
        rst_n = 1'b1;
        step();

        // Single requester, then full round-robin sweep.
        run_round(5'b10000, 5'b00000, 0, 3);
        for (int i = 0; i < 6; i++) run_round(5'b11111, 5'b00000, 0, 1);

        // Masked requester is skipped.
        run_round(5'b00011, 5'b00001, 0, 2);

        // Request withdrawn before ctrl_ready rises: nothing issued.
        req = 5'b00010; req_mask = '0; ctrl_ready = 1'b0;
        step();
        chk("norrdy_busy", 32'(busy), 32'd0);
        req = '0; ctrl_ready = 1'b1;
        step();
        step();
        chk("drop_rv", 32'(request_valid), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);

        // ctrl_ready falls in ISSUE, then returns.
        req = 5'b00100; ctrl_ready = 1'b1;
        step();
        chk("cr_issue", 32'(arb_state), 32'd1);
        ctrl_ready = 1'b0;
        step();
        chk("cr_back_idle", 32'(arb_state), 32'd0);
        chk("cr_no_rv", 32'(request_valid), 32'd0);
        step();
        chk("cr_hold_idle", 32'(busy), 32'd0);
        run_round(5'b00100, 5'b00000, 0, 4);

        // Watchdog, following index after clear, and same-cycle completion.
        run_round(5'b01000, 5'b00000, 1, 0);
        run_round(5'b11111, 5'b00000, 0, 2);
        run_round(5'b00001, 5'b00000, 0, TMO);

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] r;
            logic [N-1:0] m;
            r = N'($urandom_range(0, 31));
            m = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 31)) : '0;
            run_round(r, m, ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(1, TMO));
        end

        // Reset in the middle of a round.
        run_round(5'b00010, 5'b00000, 0, 1);
        req = 5'b11111; req_mask = '0; ctrl_ready = 1'b1;
        step();
        step();
        chk("prerst_rv", 32'(request_valid), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_rv", 32'(request_valid), 32'd0);
        chk("mrst_vec", 32'(req_vec), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_state", 32'(arb_state), 32'd0);
        rst_n = 1'b1;
        m_ptr = 0;
        req = '0; new_round = 1'b1;
        step();
        new_round = 1'b0;
        chk("stale_busy", 32'(busy), 32'd0);
        chk("stale_done", 32'(done), 32'd0);
        step();
        chk("stale_done2", 32'(done), 32'd0);
        run_round(5'b11111, 5'b00000, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
